store_write_buffer: RTL and testbench

Posted-write buffer between the datapath store path and data memory. Accepts stores from the execute/memory stage without stalling, holds them in an in-order FIFO, and drains them to data memory one per acknowledged cycle. It forwards buffered store data to same-cycle loads so the writeback select path always sees the youngest value for an address. It is the write side of the data-memory interface whose read data feeds the writeback mux.

---
 rtl/store_buf_pkg.sv | 22 ++
 rtl/sb_fwd_match.sv | 44 ++++
 rtl/store_write_buffer.sv | 101 ++++++++++
 tb/tb_store_write_buffer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buf_pkg.sv
// Shared definitions for the store write buffer.
// Holds the default geometry, the buffer entry type and a helper that strips
// the byte-offset bits from an address (all stores and loads are whole words).
package store_buf_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;

    // One buffered store. addr holds only the word address; bits [1:0] are
    // implied zero.
    typedef struct packed {
        logic                 valid;
        logic [SB_AW-1:2]     addr;
        logic [SB_DW-1:0]     data;
    } sb_entry_t;

    function automatic logic [SB_AW-1:2] word_addr(input logic [SB_AW-1:0] byte_addr);
        return byte_addr[SB_AW-1:2];
    endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding lookup.
// Compares a load word address against every valid buffered store and returns
// the data of the youngest match. Age order is recovered by walking backwards
// from the most recently written slot (wr_ptr-1).
// Ports:
//   entries  in   buffered store array
//   wr_ptr   in   next slot to be written
//   ld_req   in   load lookup qualifier
//   ld_addr  in   load byte address (bits [1:0] ignored)
//   hit      out  a valid entry matches
//   data     out  youngest matching entry data, 0 on miss
module sb_fwd_match
    import store_buf_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  sb_entry_t            entries [DEPTH],
    input  logic [PW-1:0]        wr_ptr,
    input  logic                 ld_req,
    input  logic [SB_AW-1:0]     ld_addr,
    output logic                 hit,
    output logic [SB_DW-1:0]     data
);

    logic [PW-1:0]    idx;
    logic [SB_AW-1:2] key;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        key  = word_addr(ld_addr);
        // i = 0 is the youngest slot; the first match found wins.
        for (int i = 0; i < DEPTH; i++) begin
            idx = wr_ptr - PW'(i + 1);
            if (!hit && ld_req && entries[idx].valid && entries[idx].addr == key) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write buffer between the store path and data memory.
// Stores are queued in order and drained to memory one per acknowledged cycle;
// loads see the youngest buffered value for their address combinationally.
//
// Handshakes: a store transfers on a rising edge where st_valid && st_ready;
// the source holds st_addr/st_data until then. A memory write transfers on a
// rising edge where mem_we && mem_ack; mem_addr/mem_wdata stay stable until
// then. mem_ack with mem_we low has no effect.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   st_valid/st_ready/st_addr/st_data   store input
//   ld_req/ld_addr/ld_hit/ld_data       forwarding lookup
//   mem_we/mem_addr/mem_wdata/mem_ack   memory write port
//   full/empty/count             occupancy status
module store_write_buffer
    import store_buf_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    input  logic                     ld_req,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_hit,
    output logic [DW-1:0]            ld_data,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ack,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t      entries [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count_q;
    logic           push;
    logic           pop;

    // Occupancy comes from the counter alone, so wr_ptr == rd_ptr never has
    // to be disambiguated.
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign st_ready = !full;
    assign mem_we   = !empty;

    assign push = st_valid && st_ready;
    assign pop  = mem_we && mem_ack;

    // Head entry is cleared by reset, so these read as zero while in reset.
    assign mem_addr  = {entries[rd_ptr].addr, 2'b00};
    assign mem_wdata = entries[rd_ptr].data;

    // push and pop never target the same slot: wr_ptr == rd_ptr only when
    // empty (no pop) or full (no push).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= '{valid: 1'b1, addr: word_addr(st_addr), data: st_data};
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                entries[rd_ptr].valid <= 1'b0;
                rd_ptr                <= rd_ptr + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .entries (entries),
        .wr_ptr  (wr_ptr),
        .ld_req  (ld_req),
        .ld_addr (ld_addr),
        .hit     (ld_hit),
        .data    (ld_data)
    );

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        full;
    logic        empty;
    logic [2:0]  count;

    int vectors;
    int miscompares;

    // expected memory writes, {addr, data}, in issue order
    logic [63:0] exp_q[$];

    store_write_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .ld_data   (ld_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive one store expected to be accepted at the coming edge
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        exp_q.push_back({a & 32'hFFFF_FFFC, d});
        step();
        st_valid = 1'b0;
    endtask

    task automatic drain_all(input string tag);
        int n;
        n = 0;
        mem_ack = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        mem_ack = 1'b0;
        check({tag, "_drain_bound"}, 64'(n < 50), 64'd1);
        check({tag, "_empty"}, 64'(empty), 64'd1);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    endtask

    // scoreboard: every accepted memory write must match the queue head
    always @(negedge clk) begin
        if (rst_n && mem_we && mem_ack) begin
            if (exp_q.size() == 0) begin
                check("drain_extra", {mem_addr, mem_wdata}, 64'd0);
            end else begin
                check("drain_order", {mem_addr, mem_wdata}, exp_q.pop_front());
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        ld_req   = 1'b0;
        ld_addr  = '0;
        mem_ack  = 1'b0;
        #12;
        check("rst_empty",    64'(empty),    64'd1);
        check("rst_full",     64'(full),     64'd0);
        check("rst_st_ready", 64'(st_ready), 64'd1);
        check("rst_mem_we",   64'(mem_we),   64'd0);
        check("rst_count",    64'(count),    64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // three stores, duplicate address, no ack
        store(32'h10, 32'hAAAA_0001);
        store(32'h14, 32'hAAAA_0002);
        store(32'h10, 32'hAAAA_0003);
        check("t1_count", 64'(count), 64'd3);
        check("t1_mem_addr", 64'(mem_addr), 64'h10);
        check("t1_mem_wdata", 64'(mem_wdata), 64'hAAAA_0001);
        ld_req  = 1'b1;
        ld_addr = 32'h10;
        #1;
        check("t1_ld10_hit", 64'(ld_hit), 64'd1);
        check("t1_ld10_data", 64'(ld_data), 64'hAAAA_0003);
        ld_addr = 32'h14;
        #1;
        check("t1_ld14_data", 64'(ld_data), 64'hAAAA_0002);
        ld_addr = 32'h18;
        #1;
        check("t1_ld18_hit", 64'(ld_hit), 64'd0);
        check("t1_ld18_data", 64'(ld_data), 64'd0);
        ld_req  = 1'b0;
        ld_addr = 32'h10;
        #1;
        check("t1_noreq_hit", 64'(ld_hit), 64'd0);

        // fill, fifth store refused, drain in order
        store(32'h30, 32'hAAAA_0004);
        check("t2_full", 64'(full), 64'd1);
        check("t2_st_ready", 64'(st_ready), 64'd0);
        check("t2_count", 64'(count), 64'd4);
        st_valid = 1'b1;
        st_addr  = 32'h40;
        st_data  = 32'hDEAD_BEEF;
        step();
        st_valid = 1'b0;
        check("t2_refused_count", 64'(count), 64'd4);
        drain_all("t2");

        // full with simultaneous store and ack
        for (int i = 0; i < 4; i++) store(32'h100 + 32'(i * 4), 32'hB000_0000 + 32'(i));
        st_valid = 1'b1;
        st_addr  = 32'h50;
        st_data  = 32'hC0DE_0050;
        mem_ack  = 1'b1;
        #1;
        check("t3_st_ready_full", 64'(st_ready), 64'd0);
        step();
        mem_ack = 1'b0;
        check("t3_count_after_ack", 64'(count), 64'd3);
        exp_q.push_back({32'h50, 32'hC0DE_0050});
        step();
        st_valid = 1'b0;
        check("t3_count_taken", 64'(count), 64'd4);
        drain_all("t3");

        // streaming: store and ack every cycle
        mem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 255)) << 2;
            store(a, $urandom);
            st_valid = 1'b0;
            check("t4_count", 64'(count), 64'd1);
            st_valid = 1'b1;
            st_addr  = 32'h0;
        end
        st_valid = 1'b0;
        drain_all("t4");

        // same-cycle store is not forwarded
        ld_req   = 1'b1;
        ld_addr  = 32'h20;
        st_valid = 1'b1;
        st_addr  = 32'h20;
        st_data  = 32'h55;
        #1;
        check("t5_same_cycle_hit", 64'(ld_hit), 64'd0);
        exp_q.push_back({32'h20, 32'h55});
        step();
        st_valid = 1'b0;
        check("t5_next_hit", 64'(ld_hit), 64'd1);
        check("t5_next_data", 64'(ld_data), 64'h55);
        ld_addr = 32'h23;
        #1;
        check("t5_offset_hit", 64'(ld_hit), 64'd1);
        check("t5_offset_data", 64'(ld_data), 64'h55);

        // reset mid-cycle with two entries queued
        store(32'h24, 32'h66);
        check("t6_count", 64'(count), 64'd2);
        check("t6_mem_we", 64'(mem_we), 64'd1);
        ld_addr = 32'h20;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_mem_we", 64'(mem_we), 64'd0);
        check("t6_rst_empty", 64'(empty), 64'd1);
        check("t6_rst_count", 64'(count), 64'd0);
        check("t6_rst_ld_hit", 64'(ld_hit), 64'd0);
        check("t6_rst_mem_wdata", 64'(mem_wdata), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("t6_post_ld_hit", 64'(ld_hit), 64'd0);
        check("t6_post_st_ready", 64'(st_ready), 64'd1);
        ld_req = 1'b0;
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // overall time bound
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule
